// File: rtl/ds_pkg.sv
// Shared types and default sizing for the DS sample FIFO.
package ds_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_REQ  = 2'd1,
    DS_FILL = 2'd2
  } ds_state_t;

  localparam int DS_FIFO_DEPTH = 32;
  localparam int DS_DMA_THRESH = 16;
  localparam int DS_DMA_BURST  = 4;

endpackage

// File: rtl/ds_fifo_ram.sv
// Byte storage for the DS FIFO: up to four byte writes per cycle, one asynchronous read.
module ds_fifo_ram #(
  parameter int DEPTH_BYTES = 32,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clock,
  input  logic [3:0]    byte_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH_BYTES];

  // Byte k lands k slots after the write pointer; the address wraps naturally.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (byte_en[k]) begin
        mem[wr_addr + AW'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ds_fifo.sv
// DS sample FIFO: timer-paced byte pops, word/halfword pushes, DMA refill request FSM.
// Defining DS_FIFO_ERR_EN adds the overflow/underflow pulse outputs.
module ds_fifo
  import ds_pkg::*;
#(
  parameter int DEPTH_BYTES = DS_FIFO_DEPTH,
  parameter int DMA_THRESH  = DS_DMA_THRESH,
  parameter int DMA_BURST   = DS_DMA_BURST
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic                         wr_half,
  input  logic [31:0]                  wr_data,
  input  logic                         timer0_ovf,
  input  logic                         timer1_ovf,
  input  logic                         timer_num,
  input  logic                         fifo_reset,
  output logic [23:0]                  sample_out,
  output logic [$clog2(DEPTH_BYTES):0] count,
`ifdef DS_FIFO_ERR_EN
  output logic                         overflow,
  output logic                         underflow,
`endif
  output logic                         dma_req
);

  localparam int PW = $clog2(DEPTH_BYTES);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(DMA_BURST + 1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] free_bytes, push_n, count_nxt;
  logic [3:0]    byte_en;
  logic [7:0]    rd_byte;
  logic          sel_ovf, pop, accept;
  ds_state_t     state, state_nxt;
  logic [BW-1:0] beats, beats_nxt;

  function automatic logic [23:0] sext8(input logic signed [7:0] b);
    logic signed [23:0] w;
    w = 24'(b);
    return w;
  endfunction

  assign sel_ovf    = timer_num ? timer1_ovf : timer0_ovf;
  assign pop        = sel_ovf && (count != '0) && !fifo_reset;
  // Space is judged on the pre-pop count so a write never depends on a same-cycle pop.
  assign free_bytes = CW'(DEPTH_BYTES) - count;
  assign accept     = wr_en && !fifo_reset &&
                      (free_bytes >= (wr_half ? CW'(2) : CW'(4)));
  assign push_n     = accept ? (wr_half ? CW'(2) : CW'(4)) : '0;
  assign byte_en    = accept ? (wr_half ? 4'b0011 : 4'b1111) : 4'b0000;
  assign count_nxt  = count + push_n - {{(CW-1){1'b0}}, pop};

  ds_fifo_ram #(.DEPTH_BYTES(DEPTH_BYTES), .AW(PW)) u_ram (
    .clock   (clock),
    .byte_en (byte_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_byte)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sample_out <= '0;
    end else if (fifo_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sample_out <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + (wr_half ? PW'(2) : PW'(4));
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        sample_out <= sext8(rd_byte);
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= DS_IDLE;
      beats <= '0;
    end else begin
      state <= state_nxt;
      beats <= beats_nxt;
    end
  end

  // The write that moves REQ to FILL is the first beat of the burst.
  always_comb begin
    state_nxt = state;
    beats_nxt = beats;
    if (fifo_reset) begin
      state_nxt = DS_IDLE;
      beats_nxt = '0;
    end else begin
      case (state)
        DS_IDLE: begin
          if (pop && (count_nxt <= CW'(DMA_THRESH))) begin
            state_nxt = DS_REQ;
            beats_nxt = '0;
          end
        end
        DS_REQ, DS_FILL: begin
          if (accept) begin
            beats_nxt = beats + BW'(1);
            if ((beats_nxt == BW'(DMA_BURST)) || (count_nxt == CW'(DEPTH_BYTES))) begin
              state_nxt = DS_IDLE;
              beats_nxt = '0;
            end else begin
              state_nxt = DS_FILL;
            end
          end
        end
        default: begin
          state_nxt = DS_IDLE;
          beats_nxt = '0;
        end
      endcase
    end
  end

  assign dma_req = (state != DS_IDLE);

`ifdef DS_FIFO_ERR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && !fifo_reset && !accept;
      underflow <= sel_ovf && !fifo_reset && (count == '0);
    end
  end
`endif

endmodule

// File: tb/tb_ds_fifo.sv
// Directed bench for ds_fifo: vector table for single-cycle behaviour, hand sequences for fill/wrap, threshold and reset.
module tb_ds_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_en, wr_half, timer0_ovf, timer1_ovf, timer_num, fifo_reset;
  logic [31:0] wr_data;
  logic [23:0] sample_out;
  logic [5:0]  count;
  logic        dma_req;
`ifdef DS_FIFO_ERR_EN
  logic        overflow, underflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ds_fifo dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_half    (wr_half),
    .wr_data    (wr_data),
    .timer0_ovf (timer0_ovf),
    .timer1_ovf (timer1_ovf),
    .timer_num  (timer_num),
    .fifo_reset (fifo_reset),
    .sample_out (sample_out),
    .count      (count),
`ifdef DS_FIFO_ERR_EN
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .dma_req    (dma_req)
  );

  typedef struct {
    logic        we;
    logic        hf;
    logic [31:0] wd;
    logic        t0;
    logic        t1;
    logic        tn;
    logic        fr;
    logic [23:0] es;
    logic [5:0]  ec;
    logic        ed;
    logic        eof;
    logic        euf;
  } vec_t;

  vec_t vecs [24];
  logic [7:0] exp_bytes [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic hf, input logic [31:0] wd,
                      input logic t0, input logic t1, input logic tn, input logic fr);
    wr_en = we; wr_half = hf; wr_data = wd;
    timer0_ovf = t0; timer1_ovf = t1; timer_num = tn; fifo_reset = fr;
    @(posedge clock);
    #1;
    wr_en = 1'b0; wr_half = 1'b0; timer0_ovf = 1'b0; timer1_ovf = 1'b0; fifo_reset = 1'b0;
  endtask

  initial begin
    //          we  hf  wd            t0  t1  tn  fr  sample     cnt  dma of  uf
    vecs[0]  = '{1, 0, 32'h04030201, 0, 0, 0, 0, 24'h000000, 6'd4,  0, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000001, 6'd3,  1, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000002, 6'd2,  1, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000003, 6'd1,  1, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000004, 6'd0,  1, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000004, 6'd0,  1, 0, 1};
    vecs[6]  = '{1, 0, 32'h000000FF, 0, 0, 0, 0, 24'h000004, 6'd4,  1, 0, 0};
    vecs[7]  = '{0, 0, 32'h0,        0, 1, 0, 0, 24'h000004, 6'd4,  1, 0, 0};
    vecs[8]  = '{0, 0, 32'h0,        0, 1, 1, 0, 24'hFFFFFF, 6'd3,  1, 0, 0};
    vecs[9]  = '{0, 0, 32'h0,        1, 0, 1, 0, 24'hFFFFFF, 6'd3,  1, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000000, 6'd2,  1, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000000, 6'd1,  1, 0, 0};
    vecs[12] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000000, 6'd0,  1, 0, 0};
    vecs[13] = '{1, 1, 32'hAAAA8180, 0, 0, 0, 0, 24'h000000, 6'd2,  1, 0, 0};
    vecs[14] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'hFFFF80, 6'd1,  1, 0, 0};
    vecs[15] = '{1, 0, 32'h7F060504, 1, 0, 0, 0, 24'hFFFF81, 6'd4,  1, 0, 0};
    vecs[16] = '{1, 0, 32'h0B0A0908, 0, 0, 0, 0, 24'hFFFF81, 6'd8,  0, 0, 0};
    vecs[17] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000004, 6'd7,  1, 0, 0};
    vecs[18] = '{1, 0, 32'h0F0E0D0C, 0, 0, 0, 0, 24'h000004, 6'd11, 1, 0, 0};
    vecs[19] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000005, 6'd10, 1, 0, 0};
    vecs[20] = '{1, 0, 32'h12345678, 1, 0, 0, 1, 24'h000000, 6'd0,  0, 0, 0};
    vecs[21] = '{1, 0, 32'h44332211, 0, 0, 0, 0, 24'h000000, 6'd4,  0, 0, 0};
    vecs[22] = '{0, 0, 32'h0,        1, 0, 0, 0, 24'h000011, 6'd3,  1, 0, 0};
    vecs[23] = '{0, 0, 32'h0,        0, 0, 0, 1, 24'h000000, 6'd0,  0, 0, 0};

    reset_n = 1'b0;
    wr_en = 0; wr_half = 0; wr_data = '0; timer0_ovf = 0; timer1_ovf = 0;
    timer_num = 0; fifo_reset = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset sample", 32'(sample_out), 32'h0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset dma_req", 32'(dma_req), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].we, vecs[i].hf, vecs[i].wd, vecs[i].t0, vecs[i].t1, vecs[i].tn, vecs[i].fr);
      chk($sformatf("v%0d sample", i), 32'(sample_out), 32'(vecs[i].es));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].ec));
      chk($sformatf("v%0d dma_req", i), 32'(dma_req), 32'(vecs[i].ed));
`ifdef DS_FIFO_ERR_EN
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].eof));
      chk($sformatf("v%0d underflow", i), 32'(underflow), 32'(vecs[i].euf));
`endif
    end

    // Fill to full across the pointer wrap, with drops, then drain in order.
    step(1, 0, 32'hA3A2A1A0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 1, 0, 0, 0);
    chk("fill pop0", 32'(sample_out), 32'h00FFFFA0);
    step(0, 0, 32'h0, 1, 0, 0, 0);
    chk("fill pop1", 32'(sample_out), 32'h00FFFFA1);
    chk("fill dma after pops", 32'(dma_req), 32'd1);
    exp_bytes = {8'hA2, 8'hA3};
    for (int k = 0; k < 7; k++) begin
      logic [7:0] b0;
      b0 = 8'(8'h10 + 4 * k);
      step(1, 0, {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 0, 0, 0, 0);
      for (int j = 0; j < 4; j++) exp_bytes.push_back(b0 + 8'(j));
      chk($sformatf("fill word%0d count", k), 32'(count), 32'(2 + 4 * (k + 1)));
      if (k == 3) chk("fill burst end dma", 32'(dma_req), 32'd0);
    end
    step(1, 0, 32'hEEEEEEEE, 0, 0, 0, 0);
    chk("drop word at 30", 32'(count), 32'd30);
`ifdef DS_FIFO_ERR_EN
    chk("overflow at 30", 32'(overflow), 32'd1);
`endif
    step(1, 1, 32'hEEEE2D2C, 0, 0, 0, 0);
    exp_bytes.push_back(8'h2C);
    exp_bytes.push_back(8'h2D);
    chk("half to full", 32'(count), 32'd32);
    step(1, 0, 32'hEEEEEEEE, 0, 0, 0, 0);
    chk("drop when full", 32'(count), 32'd32);
`ifdef DS_FIFO_ERR_EN
    chk("overflow when full", 32'(overflow), 32'd1);
`endif
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = exp_bytes[i];
      step(0, 0, 32'h0, 1, 0, 0, 0);
      chk($sformatf("drain%0d sample", i), 32'(sample_out), {8'h00, {16{b[7]}}, b});
      chk($sformatf("drain%0d count", i), 32'(count), 32'(31 - i));
    end

    // Threshold boundary: 17 -> 16 raises the request, four words to full drop it.
    step(0, 0, 32'h0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, 0, 32'h01020304, 0, 0, 0, 0);
    chk("thr count 20", 32'(count), 32'd20);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, 1, 0, 0, 0);
      chk($sformatf("thr above dma%0d", k), 32'(dma_req), 32'd0);
    end
    chk("thr count 17", 32'(count), 32'd17);
    step(0, 0, 32'h0, 1, 0, 0, 0);
    chk("thr count 16", 32'(count), 32'd16);
    chk("thr dma rises", 32'(dma_req), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 32'h05060708, 0, 0, 0, 0);
      chk($sformatf("thr refill%0d count", k), 32'(count), 32'(20 + 4 * k));
      chk($sformatf("thr refill%0d dma", k), 32'(dma_req), (k == 3) ? 32'd0 : 32'd1);
    end

    // Asynchronous reset in the middle of a burst.
    for (int k = 0; k < 16; k++) step(0, 0, 32'h0, 1, 0, 0, 0);
    step(1, 0, 32'h0A0B0C0D, 0, 0, 0, 0);
    chk("mid-burst dma", 32'(dma_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset count", 32'(count), 32'd0);
    chk("async reset dma", 32'(dma_req), 32'd0);
    chk("async reset sample", 32'(sample_out), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step(1, 0, 32'h11223344, 0, 0, 0, 0);
    chk("post reset count", 32'(count), 32'd4);
    chk("post reset dma", 32'(dma_req), 32'd0);
    step(0, 0, 32'h0, 1, 0, 0, 0);
    chk("post reset pop", 32'(sample_out), 32'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
